// File: rtl/repack_flush.sv
// Narrow-to-wide lane packer: D lanes of W bits become one W*D-bit word, with early flush on s_lst.
// Build option REPACK_FLUSH_MSB_FIRST_EN places lane 0 in the most significant lane of m_dat.
module repack_flush #(
  parameter int W  = 8,
  parameter int D  = 4,
  parameter int CW = $clog2(D + 1)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            s_stb,
  input  logic [W-1:0]    s_dat,
  input  logic            s_lst,
  output logic            s_rdy,
  output logic            m_stb,
  output logic [W*D-1:0]  m_dat,
  output logic [CW-1:0]   m_cnt,
  output logic            m_lst,
  input  logic            m_rdy
);

  localparam int IW = $clog2(D);

  logic [IW-1:0]        idx;
  logic [W*(D-1)-1:0]   asm_lanes;
  logic                 acc;
  logic                 done;
  logic [W*D-1:0]       word;

  // Builds the outgoing word: held lanes below last, the live lane at last, zeros above.
  function automatic logic [W*D-1:0] pack_word(
    input logic [W*(D-1)-1:0] lanes,
    input logic [IW-1:0]      last,
    input logic [W-1:0]       dat
  );
    logic [W*D-1:0] ext;
    logic [W*D-1:0] res;
    logic [W-1:0]   lane;
    ext = {{W{1'b0}}, lanes};
    res = '0;
    for (int k = 0; k < D; k++) begin
      if (k < int'(last))
        lane = ext[W*k +: W];
      else if (k == int'(last))
        lane = dat;
      else
        lane = '0;
`ifdef REPACK_FLUSH_MSB_FIRST_EN
      res[W*(D-1-k) +: W] = lane;
`else
      res[W*k +: W] = lane;
`endif
    end
    return res;
  endfunction

  always_comb begin
    s_rdy = ~m_stb | m_rdy;
    acc   = s_stb & s_rdy;
    done  = acc & (s_lst | (idx == IW'(D - 1)));
    word  = pack_word(asm_lanes, idx, s_dat);
  end

  // Input stage: lane index and assembly buffer
  always_ff @(posedge clk) begin
    if (!rst_n)
      idx <= '0;
    else if (done)
      idx <= '0;
    else if (acc)
      idx <= idx + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (acc && !done)
      asm_lanes[W*idx +: W] <= s_dat;
  end

  // Output stage: word register, reloaded on completion, emptied on a bare transfer
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      m_stb <= 1'b0;
      m_dat <= '0;
      m_cnt <= '0;
      m_lst <= 1'b0;
    end else if (done) begin
      m_stb <= 1'b1;
      m_dat <= word;
      m_cnt <= CW'(idx) + CW'(1);
      m_lst <= s_lst;
    end else if (m_rdy) begin
      m_stb <= 1'b0;
    end
  end

endmodule

// File: tb/tb_repack_flush.sv
// Table-driven bench for repack_flush (W=8, D=4) with a scoreboard queue of expected words.
module tb_repack_flush;

  localparam int W  = 8;
  localparam int D  = 4;
  localparam int CW = 3;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            s_stb;
  logic [W-1:0]    s_dat;
  logic            s_lst;
  logic            s_rdy;
  logic            m_stb;
  logic [W*D-1:0]  m_dat;
  logic [CW-1:0]   m_cnt;
  logic            m_lst;
  logic            m_rdy;

  repack_flush #(.W(W), .D(D)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_stb(s_stb), .s_dat(s_dat), .s_lst(s_lst), .s_rdy(s_rdy),
    .m_stb(m_stb), .m_dat(m_dat), .m_cnt(m_cnt), .m_lst(m_lst), .m_rdy(m_rdy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0]   dat;
    logic           lst;
    logic           done;
    logic [W*D-1:0] word;
    logic [CW-1:0]  cnt;
  } vec_t;

  typedef struct {
    logic [W*D-1:0] word;
    logic [CW-1:0]  cnt;
    logic           lst;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  logic lat_chk = 1'b0;
  logic stream_on = 1'b0;
  int   stb_hi = 0;
  int   rdy_lo = 0;

  function automatic logic [W*D-1:0] lanes(input logic [W*D-1:0] w);
`ifdef REPACK_FLUSH_MSB_FIRST_EN
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
`else
    return w;
`endif
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    n_cmp++;
    if (act !== want) begin
      n_err++;
      $display("FAIL %s: got %h, want %h", name, act, want);
    end
  endtask

  // Output monitor: pops on every transfer and checks first-word latency.
  always @(negedge clk) begin
    if (lat_chk) begin
      chk("latency_m_stb", 32'(m_stb), 32'd1);
      lat_chk = 1'b0;
    end
    if (stream_on) begin
      if (m_stb) stb_hi++;
      if (!s_rdy) rdy_lo++;
    end
    if (rst_n && m_stb && m_rdy) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_word: got %h, want none", m_dat);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("m_dat", m_dat, e.word);
        chk("m_cnt", 32'(m_cnt), 32'(e.cnt));
        chk("m_lst", 32'(m_lst), 32'(e.lst));
      end
    end
  end

  task automatic send(input logic [W-1:0] dat, input logic lst, input logic done,
                      input logic [W*D-1:0] word, input logic [CW-1:0] cnt);
    int n;
    n = 0;
    s_stb = 1'b1;
    s_dat = dat;
    s_lst = lst;
    @(negedge clk);
    while (!s_rdy && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!s_rdy) begin
      n_cmp++;
      n_err++;
      $display("FAIL send_timeout: got s_rdy=0, want 1");
    end else if (done) begin
      exp_q.push_back('{word: lanes(word), cnt: cnt, lst: lst});
    end
    @(posedge clk);
    #1;
    if (done) lat_chk = 1'b1;
    s_stb = 1'b0;
    s_lst = 1'b0;
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[$];
    tbl.push_back('{8'h11, 1'b0, 1'b0, 32'h0, 3'd0});
    tbl.push_back('{8'h22, 1'b0, 1'b0, 32'h0, 3'd0});
    tbl.push_back('{8'h33, 1'b0, 1'b0, 32'h0, 3'd0});
    tbl.push_back('{8'h44, 1'b0, 1'b1, 32'h44332211, 3'd4});
    tbl.push_back('{8'hAA, 1'b0, 1'b0, 32'h0, 3'd0});
    tbl.push_back('{8'hBB, 1'b1, 1'b1, 32'h0000BBAA, 3'd2});
    tbl.push_back('{8'h5A, 1'b1, 1'b1, 32'h0000005A, 3'd1});
    tbl.push_back('{8'hC1, 1'b0, 1'b0, 32'h0, 3'd0});
    tbl.push_back('{8'hC2, 1'b0, 1'b0, 32'h0, 3'd0});
    tbl.push_back('{8'hC3, 1'b1, 1'b1, 32'h00C3C2C1, 3'd3});
    tbl.push_back('{8'hD1, 1'b0, 1'b0, 32'h0, 3'd0});
    tbl.push_back('{8'hD2, 1'b0, 1'b0, 32'h0, 3'd0});
    tbl.push_back('{8'hD3, 1'b0, 1'b0, 32'h0, 3'd0});
    tbl.push_back('{8'hD4, 1'b1, 1'b1, 32'hD4D3D2D1, 3'd4});

    rst_n = 1'b0;
    s_stb = 1'b0;
    s_dat = '0;
    s_lst = 1'b0;
    m_rdy = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("reset_m_stb", 32'(m_stb), 32'd0);
    chk("reset_m_dat", m_dat, 32'd0);
    chk("reset_m_cnt", 32'(m_cnt), 32'd0);
    chk("reset_m_lst", 32'(m_lst), 32'd0);
    chk("reset_s_rdy", 32'(s_rdy), 32'd1);
    @(posedge clk);
    #1;

    foreach (tbl[i])
      send(tbl[i].dat, tbl[i].lst, tbl[i].done, tbl[i].word, tbl[i].cnt);
    repeat (2) @(posedge clk);
    #1;

    // Backpressure: word completes while downstream stalls; a presented lane must wait.
    m_rdy = 1'b0;
    send(8'h11, 1'b0, 1'b0, '0, '0);
    send(8'h22, 1'b0, 1'b0, '0, '0);
    send(8'h33, 1'b0, 1'b0, '0, '0);
    send(8'h44, 1'b0, 1'b1, 32'h44332211, 3'd4);
    s_stb = 1'b1;
    s_dat = 8'h99;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("bp_s_rdy", 32'(s_rdy), 32'd0);
      chk("bp_m_stb", 32'(m_stb), 32'd1);
      chk("bp_m_dat", m_dat, lanes(32'h44332211));
    end
    @(posedge clk);
    #1;
    s_stb = 1'b0;
    m_rdy = 1'b1;
    send(8'h55, 1'b0, 1'b0, '0, '0);
    send(8'h66, 1'b0, 1'b0, '0, '0);
    send(8'h77, 1'b0, 1'b0, '0, '0);
    send(8'h88, 1'b0, 1'b1, 32'h88776655, 3'd4);
    repeat (2) @(posedge clk);
    #1;

    // Streaming: 12 lanes back to back, no input stall, three words.
    stream_on = 1'b1;
    for (int i = 1; i <= 12; i++)
      send(8'(i), 1'b0, (i % 4) == 0,
           {8'(i), 8'(i - 1), 8'(i - 2), 8'(i - 3)}, 3'd4);
    repeat (2) @(posedge clk);
    #1;
    stream_on = 1'b0;
    chk("stream_stb_cycles", 32'(stb_hi), 32'd3);
    chk("stream_rdy_low", 32'(rdy_lo), 32'd0);

    // Reset mid-word discards the partial lanes.
    send(8'h01, 1'b0, 1'b0, '0, '0);
    send(8'h02, 1'b0, 1'b0, '0, '0);
    pulse_reset();
    send(8'h10, 1'b0, 1'b0, '0, '0);
    send(8'h20, 1'b0, 1'b0, '0, '0);
    send(8'h30, 1'b0, 1'b0, '0, '0);
    send(8'h40, 1'b0, 1'b1, 32'h40302010, 3'd4);
    repeat (2) @(posedge clk);
    #1;

    // Reset while a word is pending drops it.
    m_rdy = 1'b0;
    send(8'h5A, 1'b1, 1'b1, 32'h0000005A, 3'd1);
    pulse_reset();
    @(negedge clk);
    chk("rst_pend_m_stb", 32'(m_stb), 32'd0);
    chk("rst_pend_m_dat", m_dat, 32'd0);
    if (exp_q.size() > 0) void'(exp_q.pop_front());
    @(posedge clk);
    #1;
    m_rdy = 1'b1;
    send(8'hE1, 1'b1, 1'b1, 32'h000000E1, 3'd1);
    repeat (3) @(posedge clk);
    #1;

    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
